// File: rtl/aes_ctr_sequencer_pkg.sv
// Shared types and helpers for the AES-CTR sequencer: FSM states, block widths,
// and the counter-block increment with wrap detection.
package aes_ctr_pkg;

  localparam int BLK_W = 128;
  localparam int KEY_W = 128;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    LOAD  = 3'd2,
    WAIT0 = 3'd3,
    WAIT  = 3'd4,
    OUT   = 3'd5,
    HALT  = 3'd6
  } state_t;

  typedef struct packed {
    logic             wrap;
    logic [BLK_W-1:0] blk;
  } ctr_inc_t;

  // Increments only the low ctr_w bits of a counter block; the nonce field above
  // is passed through untouched so a counter wrap never carries into it.
  function automatic ctr_inc_t inc_ctr(input logic [BLK_W-1:0] ctr, input int unsigned ctr_w);
    logic [BLK_W-1:0] mask;
    ctr_inc_t         res;
    mask     = (128'd1 << ctr_w) - 128'd1;
    res.blk  = (ctr & ~mask) | ((ctr + 128'd1) & mask);
    res.wrap = ((ctr & mask) == mask);
    return res;
  endfunction

endpackage

// File: rtl/aes_ctr_sequencer_if.sv
// Request/result bus between the CTR sequencer (master) and one AES-128 core (slave).
interface aes_ctr_sequencer_if;
  import aes_ctr_pkg::*;

  logic             aes_load;
  logic             aes_enc;
  logic [BLK_W-1:0] aes_din;
  logic [KEY_W-1:0] aes_key;
  logic             aes_ready;
  logic [BLK_W-1:0] aes_dout;

  modport master (output aes_load, aes_enc, aes_din, aes_key, input aes_ready, aes_dout);
  modport slave  (input aes_load, aes_enc, aes_din, aes_key, output aes_ready, aes_dout);

endinterface

// File: rtl/aes_ctr_sequencer.sv
// AES-CTR front end: builds {nonce, ctr} blocks, runs them through one core and
// XORs the keystream with streamed data. Macro AES_CTR_WRAP_STOP_EN halts on counter wrap.
module aes_ctr_sequencer
  import aes_ctr_pkg::*;
#(
  parameter int CTR_W   = 32,
  parameter int NONCE_W = 96
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [NONCE_W-1:0] nonce,
  input  logic [CTR_W-1:0]   ctr_init,
  input  logic [KEY_W-1:0]   key,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLK_W-1:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLK_W-1:0]   out_data,
  output logic               out_last,
  aes_ctr_sequencer_if.master core,
  output logic               busy,
  output logic               err
);

  state_t           state_r, state_nxt_s;
  logic [BLK_W-1:0] blk_r;
  logic [KEY_W-1:0] key_r;
  logic [BLK_W-1:0] data_r;
  logic             last_r;
  logic [BLK_W-1:0] din_r;
  logic [BLK_W-1:0] out_data_r;
  logic             out_last_r;
  logic             in_ready_r, out_valid_r, aes_load_r, busy_r, err_r;
  logic             in_ready_s, out_valid_s, aes_load_s, busy_s, err_s;
  logic             accept_s, leave_out_s, result_s;
  ctr_inc_t         ctr_inc_s;

  assign ctr_inc_s   = inc_ctr(blk_r, CTR_W);
  assign accept_s    = in_valid & in_ready_r;
  assign leave_out_s = (state_r == OUT) & out_ready;
  // A ready seen in WAIT0 may belong to the previous block, so only WAIT listens.
  assign result_s    = (state_r == WAIT) & core.aes_ready;

`ifndef AES_CTR_WRAP_STOP_EN
  logic unused_wrap_s;
  assign unused_wrap_s = ctr_inc_s.wrap;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:  if (start) state_nxt_s = ARM; else state_nxt_s = IDLE;
      ARM:   if (accept_s) state_nxt_s = LOAD; else state_nxt_s = ARM;
      LOAD:  state_nxt_s = WAIT0;
      WAIT0: state_nxt_s = WAIT;
      WAIT:  if (core.aes_ready) state_nxt_s = OUT; else state_nxt_s = WAIT;
      OUT: begin
        if (!out_ready)           state_nxt_s = OUT;
`ifdef AES_CTR_WRAP_STOP_EN
        else if (ctr_inc_s.wrap)  state_nxt_s = HALT;
`endif
        else if (last_r)          state_nxt_s = IDLE;
        else                      state_nxt_s = ARM;
      end
`ifdef AES_CTR_WRAP_STOP_EN
      HALT:  state_nxt_s = HALT;
`endif
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the flags register in step with it
  always_comb begin
    in_ready_s  = (state_nxt_s == ARM);
    out_valid_s = (state_nxt_s == OUT);
    aes_load_s  = (state_nxt_s == LOAD);
    busy_s      = (state_nxt_s != IDLE);
`ifdef AES_CTR_WRAP_STOP_EN
    err_s       = (state_nxt_s == HALT);
`else
    err_s       = 1'b0;
`endif
  end

  // Registered control outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      aes_load_r  <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      aes_load_r  <= aes_load_s;
      busy_r      <= busy_s;
      err_r       <= err_s;
    end
  end

  // Counter block, key, captured input and XOR result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_r      <= {BLK_W{1'b0}};
      key_r      <= {KEY_W{1'b0}};
      data_r     <= {BLK_W{1'b0}};
      last_r     <= 1'b0;
      din_r      <= {BLK_W{1'b0}};
      out_data_r <= {BLK_W{1'b0}};
      out_last_r <= 1'b0;
    end else begin
      if ((state_r == IDLE) && start) begin
        blk_r <= {nonce, ctr_init};
        key_r <= key;
      end else if (leave_out_s) begin
        blk_r <= ctr_inc_s.blk;
      end
      if (accept_s) begin
        data_r <= in_data;
        last_r <= in_last;
        din_r  <= blk_r;
      end
      if (result_s) begin
        out_data_r <= data_r ^ core.aes_dout;
        out_last_r <= last_r;
      end
    end
  end

  assign in_ready      = in_ready_r;
  assign out_valid     = out_valid_r;
  assign out_data      = out_data_r;
  assign out_last      = out_last_r;
  assign busy          = busy_r;
  assign err           = err_r;
  assign core.aes_load = aes_load_r;
  assign core.aes_enc  = 1'b0;
  assign core.aes_din  = din_r;
  assign core.aes_key  = key_r;

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// Self-checking bench for aes_ctr_sequencer with a behavioural AES-128 core
// (fixed latency, ready stays high until the next load). Honours AES_CTR_WRAP_STOP_EN.
module tb_aes_ctr_sequencer;

  localparam int CORE_LAT = 3;

  typedef struct {
    logic [127:0] key;
    logic [95:0]  nonce;
    logic [31:0]  ctr;
    logic [127:0] data;
    logic [127:0] exp_out;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [95:0]  nonce = '0;
  logic [31:0]  ctr_init = '0;
  logic [127:0] key = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         out_last;
  logic         busy;
  logic         err;

  int passed = 0;
  int total  = 0;

  logic [7:0]   sbox [256];
  logic [7:0]   sb_inv;
  vec_t         vecs [5];

  aes_ctr_sequencer_if core_if ();

  aes_ctr_sequencer #(.CTR_W(32), .NONCE_W(96)) dut (
    .clk(clk), .reset(reset), .start(start), .nonce(nonce), .ctr_init(ctr_init), .key(key),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core(core_if), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [127:0] aes128(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [7:0]   s [16];
    logic [7:0]   n [16];
    logic [127:0] rk, res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int r = 0; r <= 10; r++) begin
      if (r > 0) begin
        for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
        for (int c = 0; c < 4; c++)
          for (int q = 0; q < 4; q++) n[q+4*c] = s[q+4*((c+q)%4)];
        if (r < 10) begin
          for (int c = 0; c < 4; c++) begin
            a0 = n[4*c]; a1 = n[4*c+1]; a2 = n[4*c+2]; a3 = n[4*c+3];
            s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
          end
        end else begin
          for (int i = 0; i < 16; i++) s[i] = n[i];
        end
      end
      rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Core model: result after CORE_LAT cycles; ready/dout stay stale until the next load completes
  int           core_cnt = 0;
  logic [127:0] core_res = '0;
  logic         core_rdy = 1'b0;
  logic [127:0] core_out = '0;
  assign core_if.aes_ready = core_rdy;
  assign core_if.aes_dout  = core_out;

  always @(posedge clk) begin
    if (core_if.aes_load) begin
      core_cnt <= CORE_LAT;
      core_res <= aes128(core_if.aes_key, core_if.aes_din);
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
      core_rdy <= 1'b0;
    end else if (core_cnt == 1) begin
      core_cnt <= 0;
      core_rdy <= 1'b1;
      core_out <= core_res;
    end
  end

  int           load_cnt = 0;
  logic [127:0] din_log [64];
  always @(posedge clk) begin
    if (core_if.aes_load) begin
      din_log[load_cnt % 64] <= core_if.aes_din;
      load_cnt <= load_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_start(input logic [127:0] k, input logic [95:0] n, input logic [31:0] c);
    key = k; nonce = n; ctr_init = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [127:0] d, input logic l);
    int cnt;
    in_valid = 1'b1; in_data = d; in_last = l;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("input accepted", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv(input int stall, output logic [127:0] d, output logic l);
    int cnt;
    if (stall == 0) out_ready = 1'b1;
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("out_valid seen", out_valid, 1);
    d = out_data; l = out_last;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk($sformatf("stall hold %0d", i), {out_valid, out_data}, {1'b1, d});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [127:0] got, kk, dd [3];
  logic [95:0]  nn;
  logic         gl;
  int           base;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int x = 0; x < 256; x++) begin
      sb_inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) sb_inv = 8'(y);
      sbox[x] = sb_inv ^ rotl8(sb_inv, 1) ^ rotl8(sb_inv, 2) ^ rotl8(sb_inv, 3) ^ rotl8(sb_inv, 4) ^ 8'h63;
    end
    vecs[0] = '{128'h0, 96'h0, 32'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    vecs[1] = '{128'h0, 96'hf34481ec3cc627bacd5dc3fb, 32'h08f273e6, 128'h0,
                128'h0336763e966d92595a567cc9ce537f5e};
    vecs[2] = '{128'h0, 96'h0, 32'h0, {128{1'b1}}, 128'h9916b42b1075d3c477b305a635cbd4d1};
    vecs[3] = '{128'h0, 96'h9798c4640bad75c7c3227db9, 32'h10174e72, 128'h0,
                128'ha9a1631bf4996954ebc093957b234589};
    vecs[4] = '{128'h0, 96'hf34481ec3cc627bacd5dc3fb, 32'h08f273e6,
                128'h0336763e966d92595a567cc9ce537f5e, 128'h0};

    // Reset state
    @(negedge clk);
    chk("reset flags", {in_ready, out_valid, out_last, core_if.aes_load, busy, err}, 6'b0);
    chk("reset out_data", out_data, 128'h0);
    chk("reset aes_din", core_if.aes_din, 128'h0);
    chk("reset aes_key", core_if.aes_key, 128'h0);
    chk("aes_enc", core_if.aes_enc, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // Single-block known-answer vectors
    for (int i = 0; i < 5; i++) begin
      base = load_cnt;
      do_start(vecs[i].key, vecs[i].nonce, vecs[i].ctr);
      send(vecs[i].data, 1'b1);
      recv(0, got, gl);
      chk($sformatf("vec%0d out_data", i), got, vecs[i].exp_out);
      chk($sformatf("vec%0d out_last", i), gl, 1'b1);
      chk($sformatf("vec%0d aes_din", i), din_log[base % 64], {vecs[i].nonce, vecs[i].ctr});
      chk($sformatf("vec%0d loads", i), load_cnt - base, 1);
      chk($sformatf("vec%0d idle", i), busy, 1'b0);
    end

    // Three blocks, block 1 stalled 5 cycles; stale ready from the prior block must be ignored
    kk = 128'h000102030405060708090a0b0c0d0e0f;
    nn = 96'hcafebabedeadbeef01234567;
    dd[0] = 128'h00112233445566778899aabbccddeeff;
    dd[1] = 128'hffeeddccbbaa99887766554433221100;
    dd[2] = 128'h0123456789abcdeffedcba9876543210;
    base = load_cnt;
    do_start(kk, nn, 32'h0);
    chk("multi aes_key", core_if.aes_key, kk);
    for (int b = 0; b < 3; b++) begin
      send(dd[b], b == 2);
      recv(b == 1 ? 5 : 0, got, gl);
      chk($sformatf("multi%0d out_data", b), got, dd[b] ^ aes128(kk, {nn, 32'(b)}));
      chk($sformatf("multi%0d out_last", b), gl, b == 2);
      chk($sformatf("multi%0d aes_din", b), din_log[(base + b) % 64], {nn, 32'(b)});
    end
    chk("multi loads", load_cnt - base, 3);
    chk("multi idle", busy, 1'b0);

    // start during WAIT with another nonce/key must be ignored
    base = load_cnt;
    do_start(kk, nn, 32'h5);
    send(dd[0], 1'b0);
    @(negedge clk);
    @(negedge clk);
    do_start(128'hffff, 96'h111111111111, 32'h0);
    recv(0, got, gl);
    chk("ignstart blk0", got, dd[0] ^ aes128(kk, {nn, 32'h5}));
    send(dd[1], 1'b1);
    recv(0, got, gl);
    chk("ignstart blk1", got, dd[1] ^ aes128(kk, {nn, 32'h6}));
    chk("ignstart din1", din_log[(base + 1) % 64], {nn, 32'h6});
    chk("ignstart idle", busy, 1'b0);

    // Reset while waiting on the core, then a clean restart
    do_start(kk, nn, 32'h7);
    send(dd[2], 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset flags", {in_ready, out_valid, out_last, core_if.aes_load, busy, err}, 6'b0);
    chk("midreset out_data", out_data, 128'h0);
    chk("midreset aes_din", core_if.aes_din, 128'h0);
    chk("midreset aes_key", core_if.aes_key, 128'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_start(128'h0, 96'h0, 32'h0);
    send(128'h0, 1'b1);
    recv(0, got, gl);
    chk("after reset out_data", got, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    chk("after reset idle", busy, 1'b0);

    // Counter wrap from ffffffff
    base = load_cnt;
    do_start(kk, nn, 32'hffffffff);
    send(dd[0], 1'b0);
    recv(0, got, gl);
    chk("wrap blk0", got, dd[0] ^ aes128(kk, {nn, 32'hffffffff}));
`ifdef AES_CTR_WRAP_STOP_EN
    chk("halt busy/err/in_ready", {busy, err, in_ready}, 3'b110);
    in_valid = 1'b1; in_data = dd[1];
    repeat (5) @(negedge clk);
    chk("halt in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    do_start(kk, nn, 32'h0);
    @(negedge clk);
    chk("halt holds", {busy, err}, 2'b11);
    chk("halt loads", load_cnt - base, 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("halt cleared", {busy, err}, 2'b00);
`else
    chk("wrap err", err, 1'b0);
    send(dd[1], 1'b1);
    recv(0, got, gl);
    chk("wrap blk1", got, dd[1] ^ aes128(kk, {nn, 32'h0}));
    chk("wrap din1", din_log[(base + 1) % 64], {nn, 32'h0});
    chk("wrap idle err", {busy, err}, 2'b00);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
